// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs structured RV32I instruction fields (R, I-ALU, LOAD, STORE, BRANCH,
//   JAL) into 32-bit words and streams them through a small FIFO into the
//   instruction-memory write port. Boot/test logic uses it to load programs
//   beat by beat.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               one-cycle pulse, begins a session (IDLE only)
//   in_valid_i/in_ready_o input beat handshake, in_last_i ends the session
//   in_class_i            0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL
//   in_funct3_i, in_f7b5_i, in_rd_i, in_rs1_i, in_rs2_i, in_imm_i  fields
//   imem_ready_i          memory accepts a write this cycle
//   imem_we_o/imem_addr_o/imem_wdata_o  memory write port (byte address)
//   busy_o, done_o, err_o, word_count_o status
//
// Build option
//   ENC_RANGE_CHECK_EN    when defined, immediates that do not fit their
//                         field (or are misaligned) make the beat illegal.
module instr_encoder_loader #(
  parameter int              AW        = 8,
  parameter int              DEPTH     = 4,
  parameter logic [AW-1:0]   BASE_ADDR = '0
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          in_last_i,
  input  logic [2:0]    in_class_i,
  input  logic [2:0]    in_funct3_i,
  input  logic          in_f7b5_i,
  input  logic [4:0]    in_rd_i,
  input  logic [4:0]    in_rs1_i,
  input  logic [4:0]    in_rs2_i,
  input  logic [20:0]   in_imm_i,
  input  logic          imem_ready_i,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [15:0]   word_count_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e         state_q;
  logic           busy_q, done_q, err_q;
  logic [AW-1:0]  addr_q;
  logic [15:0]    wc_q;

  logic [31:0]    mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count_q, count_d;

  logic           fifo_full, fifo_empty;
  logic           accept, push, pop;
  logic [31:0]    enc_word;
  logic           class_ok, range_ok, legal;
  logic           is_shift;

  assign fifo_full  = (count_q == (PW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // in_ready looks only at the registered occupancy, so a pop in the same
  // cycle never opens the door for a push into a full FIFO.
  assign in_ready_o = (state_q == S_RUN) && !fifo_full;
  assign accept     = in_valid_i && in_ready_o;
  assign push       = accept && legal;

  // Gated by reset so nothing reaches memory in the reset cycle.
  assign imem_we_o    = !fifo_empty && imem_ready_i && !reset_i;
  assign pop          = imem_we_o;
  assign imem_wdata_o = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  assign imem_addr_o  = addr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = wc_q;

  assign is_shift = (in_funct3_i == 3'b001) || (in_funct3_i == 3'b101);

  // Field packing for each instruction class.
  always_comb begin
    enc_word = 32'h0;
    class_ok = 1'b1;
    case (in_class_i)
      3'd0: enc_word = {1'b0, in_f7b5_i, 5'b0, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, 7'b0110011};
      3'd1: begin
        if (is_shift)
          enc_word = {1'b0, in_f7b5_i, 5'b0, in_imm_i[4:0], in_rs1_i, in_funct3_i, in_rd_i, 7'b0010011};
        else
          enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'b0010011};
      end
      3'd2: enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'b0000011};
      3'd3: enc_word = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0], 7'b0100011};
      3'd4: enc_word = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                        in_imm_i[4:1], in_imm_i[11], 7'b1100011};
      3'd5: enc_word = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12], in_rd_i, 7'b1101111};
      default: class_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic imm12_ok, shamt_ok, br_ok, jal_ok;
  // A value fits a signed N-bit field when all bits from N-1 upward agree.
  assign imm12_ok = (&in_imm_i[20:11]) || !(|in_imm_i[20:11]);
  assign shamt_ok = !(|in_imm_i[20:5]);
  assign br_ok    = ((&in_imm_i[20:12]) || !(|in_imm_i[20:12])) && !in_imm_i[0];
  assign jal_ok   = !in_imm_i[0];

  always_comb begin
    range_ok = 1'b1;
    case (in_class_i)
      3'd1:       range_ok = is_shift ? shamt_ok : imm12_ok;
      3'd2, 3'd3: range_ok = imm12_ok;
      3'd4:       range_ok = br_ok;
      3'd5:       range_ok = jal_ok;
      default:    range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  assign legal = class_ok && range_ok;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage: no reset needed, pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= BASE_ADDR;
      wc_q     <= 16'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        addr_q   <= addr_q + AW'(4);
        if (wc_q != 16'hFFFF) wc_q <= wc_q + 16'h1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            wc_q    <= 16'h0;
            addr_q  <= BASE_ADDR;
          end
        end
        S_RUN: begin
          if (accept && !legal) err_q <= 1'b1;
          if (accept && in_last_i) begin
            // Skip DRAIN when the FIFO will already be empty.
            if (count_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (count_d == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, in_last;
  logic [2:0]    in_class, in_funct3;
  logic          in_f7b5;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [20:0]   in_imm;
  logic          imem_ready, imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done, err;
  logic [15:0]   word_count;

  always #5 clk = ~clk;

  instr_encoder_loader #(.AW(AW), .DEPTH(DEPTH), .BASE_ADDR(8'h00)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
    .in_class_i(in_class), .in_funct3_i(in_funct3), .in_f7b5_i(in_f7b5),
    .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_imm_i(in_imm),
    .imem_ready_i(imem_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .busy_o(busy), .done_o(done), .err_o(err),
    .word_count_o(word_count)
  );

  int            vectors = 0;
  int            miscompares = 0;
  logic [31:0]   exp_q[$];
  logic [AW-1:0] m_addr;
  int            m_wc;
  bit            m_err;
  bit            rdy_rand;

  logic          s_in_ready, s_done, s_busy, s_err, s_we;
  logic [15:0]   s_wc;
  logic [AW-1:0] s_addr;

  // Reference encoder: fields extracted arithmetically from the immediate.
  function automatic int fb(int v, int hi, int lo);
    return (v >>> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic logic [31:0] ref_enc(int cls, int f3, int f7, int rd, int rs1, int rs2, int imm);
    int w;
    int base;
    base = (f3 << 12) | (rs1 << 15);
    case (cls)
      0: w = 'h33 | (rd << 7) | base | (rs2 << 20) | (f7 << 30);
      1: begin
        if (f3 == 1 || f3 == 5) w = 'h13 | (rd << 7) | base | (fb(imm, 4, 0) << 20) | (f7 << 30);
        else                    w = 'h13 | (rd << 7) | base | (fb(imm, 11, 0) << 20);
      end
      2: w = 'h03 | (rd << 7) | base | (fb(imm, 11, 0) << 20);
      3: w = 'h23 | (fb(imm, 4, 0) << 7) | base | (rs2 << 20) | (fb(imm, 11, 5) << 25);
      4: w = 'h63 | (fb(imm, 11, 11) << 7) | (fb(imm, 4, 1) << 8) | base | (rs2 << 20)
             | (fb(imm, 10, 5) << 25) | (fb(imm, 12, 12) << 31);
      5: w = 'h6F | (rd << 7) | (fb(imm, 19, 12) << 12) | (fb(imm, 11, 11) << 20)
             | (fb(imm, 10, 1) << 21) | (fb(imm, 20, 20) << 31);
      default: w = 0;
    endcase
    return 32'(w);
  endfunction

  function automatic bit ref_legal(int cls, int f3, int imm);
    if (cls > 5) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    if (cls == 1 && (f3 == 1 || f3 == 5)) return (imm >= 0 && imm <= 31);
    if (cls >= 1 && cls <= 3) return (imm >= -2048 && imm <= 2047);
    if (cls == 4) return (imm >= -4096 && imm <= 4094 && (imm % 2) == 0);
    if (cls == 5) return ((imm % 2) == 0);
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, check any memory write, advance.
  task automatic cyc();
    @(negedge clk);
    s_in_ready = in_ready; s_done = done; s_busy = busy; s_err = err;
    s_we = imem_we; s_wc = word_count; s_addr = imem_addr;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", {31'b0, imem_we}, 32'd0);
      end else begin
        chk("wdata", imem_wdata, exp_q[0]);
        chk("waddr", 32'(imem_addr), 32'(m_addr));
        $display("write @%h = %h", imem_addr, imem_wdata);
        void'(exp_q.pop_front());
        m_addr = m_addr + 8'd4;
        m_wc++;
      end
    end
    @(posedge clk);
    #1;
    if (rdy_rand) imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_session();
    start = 1'b1;
    cyc();
    start = 1'b0;
    m_addr = 8'h00; m_wc = 0; m_err = 1'b0;
    cyc();
    chk("busy_after_start", {31'b0, s_busy}, 32'd1);
    chk("wc_after_start", {16'b0, s_wc}, 32'd0);
  endtask

  task automatic send(input int cls, input int f3, input int f7, input int rd, input int rs1,
                      input int rs2, input int imm, input bit last, input bit use_exp,
                      input logic [31:0] exp_word);
    bit acc;
    acc = 1'b0;
    in_class = 3'(cls); in_funct3 = 3'(f3); in_f7b5 = 1'(f7);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 21'(imm);
    in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      cyc();
      if (s_in_ready === 1'b1) acc = 1'b1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("beat_accepted", {31'b0, acc}, 32'd1);
    if (acc) begin
      if (ref_legal(cls, f3, imm)) exp_q.push_back(use_exp ? exp_word : ref_enc(cls, f3, f7, rd, rs1, rs2, imm));
      else m_err = 1'b1;
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      cyc();
      if (s_done === 1'b1) got = 1'b1;
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    chk("done_wc", {16'b0, s_wc}, 32'(m_wc));
    chk("done_err", {31'b0, s_err}, {31'b0, m_err});
    chk("done_pending", 32'(exp_q.size()), 32'd0);
    cyc();
    chk("idle_busy", {31'b0, s_busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_class = '0; in_funct3 = '0; in_f7b5 = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; imem_ready = 1'b1; rdy_rand = 1'b0;
    m_addr = 8'h00; m_wc = 0; m_err = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_busy", {31'b0, s_busy}, 32'd0);
    chk("rst_done", {31'b0, s_done}, 32'd0);
    chk("rst_err", {31'b0, s_err}, 32'd0);
    chk("rst_we", {31'b0, s_we}, 32'd0);
    chk("rst_in_ready", {31'b0, s_in_ready}, 32'd0);
    chk("rst_wc", {16'b0, s_wc}, 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);

    // Single R-type beat: write next cycle, done the one after.
    start_session();
    send(0, 0, 0, 3, 1, 2, 0, 1'b1, 1'b1, 32'h002081B3);
    cyc();
    chk("t1_we", {31'b0, s_we}, 32'd1);
    chk("t1_done_early", {31'b0, s_done}, 32'd0);
    cyc();
    chk("t1_done", {31'b0, s_done}, 32'd1);
    chk("t1_wc", {16'b0, s_wc}, 32'd1);
    cyc();
    chk("t1_idle", {31'b0, s_busy}, 32'd0);

    // I-ALU then STORE.
    start_session();
    send(1, 0, 0, 5, 0, 0, -1, 1'b0, 1'b1, 32'hFFF00293);
    send(3, 2, 0, 0, 1, 2, 8, 1'b1, 1'b1, 32'h0020A423);
    wait_done();

    // BRANCH then JAL.
    start_session();
    send(4, 0, 0, 0, 1, 2, -4, 1'b0, 1'b1, 32'hFE208EE3);
    send(5, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'h0000006F);
    wait_done();

    // Back-pressure: FIFO fills with 4 beats, 5th waits for memory.
    imem_ready = 1'b0;
    start_session();
    for (int i = 0; i < 4; i++) send(0, i, 0, i + 1, i + 2, i + 3, 0, 1'b0, 1'b0, 32'h0);
    in_class = 3'd0; in_rd = 5'd9; in_valid = 1'b1;
    cyc();
    chk("bp_ready_low0", {31'b0, s_in_ready}, 32'd0);
    cyc();
    chk("bp_ready_low1", {31'b0, s_in_ready}, 32'd0);
    chk("bp_no_write", {16'b0, s_wc}, 32'd0);
    in_valid = 1'b0;
    imem_ready = 1'b1;
    send(0, 0, 1, 9, 4, 5, 0, 1'b1, 1'b0, 32'h0);
    wait_done();
    chk("bp_wc5", 32'(m_wc), 32'd5);

    // Illegal class ends the session with err and no write.
    start_session();
    send(7, 0, 0, 1, 1, 1, 0, 1'b1, 1'b0, 32'h0);
    cyc();
    chk("ill_done", {31'b0, s_done}, 32'd1);
    chk("ill_err", {31'b0, s_err}, 32'd1);
    chk("ill_wc", {16'b0, s_wc}, 32'd0);
    cyc();

`ifdef ENC_RANGE_CHECK_EN
    start_session();
    send(4, 0, 0, 0, 1, 2, 3, 1'b1, 1'b0, 32'h0);
    cyc();
    chk("rng_done", {31'b0, s_done}, 32'd1);
    chk("rng_err", {31'b0, s_err}, 32'd1);
    chk("rng_wc", {16'b0, s_wc}, 32'd0);
    cyc();
`endif

    // Reset while draining two queued words.
    start_session();
    send(0, 0, 0, 1, 1, 1, 0, 1'b0, 1'b0, 32'h0);
    cyc();
    imem_ready = 1'b0;
    send(0, 1, 0, 2, 2, 2, 0, 1'b0, 1'b0, 32'h0);
    send(0, 2, 0, 3, 3, 3, 0, 1'b1, 1'b0, 32'h0);
    cyc();
    chk("drain_busy", {31'b0, s_busy}, 32'd1);
    chk("drain_wc", {16'b0, s_wc}, 32'd1);
    exp_q.delete();
    reset = 1'b1;
    imem_ready = 1'b1;
    cyc();
    chk("rstcyc_we", {31'b0, s_we}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("midrst_busy", {31'b0, s_busy}, 32'd0);
    chk("midrst_wc", {16'b0, s_wc}, 32'd0);
    chk("midrst_addr", 32'(s_addr), 32'd0);
    chk("midrst_we", {31'b0, s_we}, 32'd0);
    cyc(); cyc();

    // Randomized sessions with random memory back-pressure.
    rdy_rand = 1'b1;
    for (int s = 0; s < 8; s++) begin
      int nb;
      nb = int'($urandom_range(1, 8));
      start_session();
      for (int b = 0; b < nb; b++) begin
        int cls, f3, imm;
        cls = int'($urandom_range(0, 7));
        f3  = int'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) imm = int'($urandom_range(0, 80)) - 40;
        else imm = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
        send(cls, f3, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm,
             (b == nb - 1), 1'b0, 32'h0);
      end
      wait_done();
    end
    rdy_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
